wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Write-back stage of the CompactRISC16 datapath. Sits directly upstream of the register-file write-select decoder.
- Merges single-cycle ALU results and in-order memory-load returns into one registered write port: 4-bit destination index, enable and 16-bit data. The index/enable pair drives the 4-to-16 write-select decoder.
- Tracks loads in flight with a tag FIFO and a 16-bit busy scoreboard, used by issue logic for hazard stalls.

Parameters:
- LD_DEPTH, 4, max outstanding loads (tag FIFO depth); power of two, 2..16.
- DATA_WIDTH, 16, register data width.

Ports:
- I_CLK  input  1  system clock, rising edge.
- I_NRESET  input  1  asynchronous active-low reset.
- I_ALU_VALID  input  1  ALU result present this cycle.
- I_ALU_REG  input  4  ALU destination register.
- I_ALU_DATA  input  DATA_WIDTH  ALU result.
- O_ALU_READY  output  1  ALU result accepted when VALID&READY.
- I_LD_ISSUE  input  1  load issued to memory this cycle.
- I_LD_REG  input  4  load destination register.
- O_LD_ISSUE_READY  output  1  tag FIFO not full.
- I_LD_RESP_VALID  input  1  memory return data valid; no backpressure, in issue order.
- I_LD_RESP_DATA  input  DATA_WIDTH  load data.
- O_WB_ENABLE  output  1  register-file write enable (to decoder enable).
- O_WB_REG  output  4  write index (to decoder input).
- O_WB_DATA  output  DATA_WIDTH  write data.
- O_BUSY  output  16  bit i set = load pending to register i.
- O_ERROR  output  1  sticky protocol error.

Behaviour:
- Reset (async, I_NRESET=0): O_WB_ENABLE=0, O_WB_REG=0, O_WB_DATA=0, O_BUSY=0, O_ERROR=0. FIFO empty, hold buffer empty, FSM=IDLE. Asserts mid-operation discard all in-flight loads; no write issues after release until new traffic.
- All O_WB_* are registered. Exactly one write per cycle at most.
- FSM states:
  - IDLE: hold buffer empty; O_ALU_READY=1.
  - HELD: hold buffer holds one load return; O_ALU_READY=0.
- Arbitration in IDLE:
  - ALU accept only → write ALU at N+1.
  - Load response only → write load at N+1.
  - Both → ALU written at N+1; load captured into hold buffer with its popped tag; go HELD.
- In HELD: hold buffer written at N+1, return to IDLE.
  - A new load response in the same cycle is written at N+2 via the hold buffer, which is reloaded; stay HELD.
  - ALU remains stalled while HELD.
- Latency: ALU 1 cycle. Load 1 cycle, 2 if colliding; sustained back-to-back responses add no further delay.
- Tag FIFO:
  - Push I_LD_REG on I_LD_ISSUE & O_LD_ISSUE_READY. Pop on each I_LD_RESP_VALID.
  - O_LD_ISSUE_READY = count < LD_DEPTH (from registered count); push and pop in the same cycle are legal at any count.
  - Pointers wrap modulo LD_DEPTH.
- Scoreboard:
  - Set bit on accepted issue; clear bit when that load's O_WB_ENABLE cycle is registered.
  - Set and clear of the same bit in the same cycle → set wins.
- Errors (set O_ERROR, sticky until reset):
  - Response with FIFO empty: response dropped.
  - Issue while not ready: issue ignored, busy unchanged.
  - Accepted ALU write to a register whose O_BUSY bit is set: write still performed.
- Width rule: data passes unmodified; no sign extension.

Decomposition:
- Shared package cr16_pkg: DATA_WIDTH default, REG_ADDR_WIDTH=4, NUM_REGS=16, FSM state encodings (IDLE=1'b0, HELD=1'b1).
- One sub-module: wb_tag_fifo, a synchronous FIFO of 4-bit tags with parameter LD_DEPTH and full/empty/count outputs, async active-low reset.

Test Plan:
- ALU only: I_ALU_VALID=1, REG=3, DATA=16'hBEEF at cycle 5 → cycle 6 O_WB_ENABLE=1, O_WB_REG=3, O_WB_DATA=16'hBEEF, O_BUSY=0.
- Load round trip: issue REG=7 at cycle 2 → O_BUSY=16'h0080 at cycle 3. Response 16'h1234 at cycle 6 → cycle 7 write R7=16'h1234; O_BUSY=0 at cycle 8.
- Collision: load to R2 pending, then ALU R5=16'h0011 and response 16'h2222 both at cycle N → N+1 writes R5, O_ALU_READY=0 at N+1, N+2 writes R2=16'h2222, READY=1 at N+2.
- FIFO full and wrap: issue R1..R4 back-to-back → O_LD_ISSUE_READY=0 after the 4th. Extra issue of R9 sets O_ERROR, R9 never busy. Return 4 responses, then issue R9 → written to R9 in order (pointer wrap).
- Same-cycle set/clear: response for pending R6 plus new issue of R6 in the same cycle → O_BUSY[6] stays 1 until the second response writes.
- Reset mid-flight: 3 loads pending, pulse I_NRESET low asynchronously (between edges) → all outputs 0 immediately. Later responses with empty FIFO set O_ERROR and produce no write.

Source files
------------

// File: rtl/cr16_pkg.sv
// Shared CompactRISC16 definitions: register-file geometry, write-back FSM
// encoding and a register-index to one-hot mask helper.
package cr16_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int NUM_REGS       = 16;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_HELD = 1'b1
    } wb_state_e;

    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_WIDTH-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/wb_tag_fifo.sv
// In-order FIFO of load destination tags; head is visible on pop_tag
// whenever the FIFO is not empty.
module wb_tag_fifo
    import cr16_pkg::*;
#(
    parameter int LD_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [REG_ADDR_WIDTH-1:0]     push_tag,
    input  logic                          pop,
    output logic [REG_ADDR_WIDTH-1:0]     pop_tag,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(LD_DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(LD_DEPTH);
    localparam int CNT_W = $clog2(LD_DEPTH + 1);

    logic [REG_ADDR_WIDTH-1:0] mem [LD_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic                      do_push;
    logic                      do_pop;

    assign full    = (count == CNT_W'(LD_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_tag = mem[rd_ptr];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and in-order load returns into one
// registered register-file write port, and tracks pending loads per register.
module wb_arbiter
    import cr16_pkg::*;
#(
    parameter int LD_DEPTH   = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                      I_CLK,
    input  logic                      I_NRESET,
    input  logic                      I_ALU_VALID,
    input  logic [REG_ADDR_WIDTH-1:0] I_ALU_REG,
    input  logic [DATA_WIDTH-1:0]     I_ALU_DATA,
    output logic                      O_ALU_READY,
    input  logic                      I_LD_ISSUE,
    input  logic [REG_ADDR_WIDTH-1:0] I_LD_REG,
    output logic                      O_LD_ISSUE_READY,
    input  logic                      I_LD_RESP_VALID,
    input  logic [DATA_WIDTH-1:0]     I_LD_RESP_DATA,
    output logic                      O_WB_ENABLE,
    output logic [REG_ADDR_WIDTH-1:0] O_WB_REG,
    output logic [DATA_WIDTH-1:0]     O_WB_DATA,
    output logic [NUM_REGS-1:0]       O_BUSY,
    output logic                      O_ERROR
);

    localparam int CNT_W = $clog2(LD_DEPTH + 1);

    wb_state_e                 state;
    wb_state_e                 state_nxt;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [REG_ADDR_WIDTH-1:0] head_tag;
    logic                      alu_acc;
    logic                      issue_acc;
    logic                      resp_acc;
    logic                      hold_load;
    logic [REG_ADDR_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0]     hold_data;
    logic                      wb_en_d;
    logic                      wb_load_d;
    logic [REG_ADDR_WIDTH-1:0] wb_reg_d;
    logic [DATA_WIDTH-1:0]     wb_data_d;
    logic [NUM_REGS-1:0]       busy_nxt;
    logic                      err_d;

    assign O_ALU_READY      = (state == WB_IDLE);
    assign O_LD_ISSUE_READY = (fifo_count < CNT_W'(LD_DEPTH));
    assign alu_acc          = I_ALU_VALID & O_ALU_READY;
    assign issue_acc        = I_LD_ISSUE & O_LD_ISSUE_READY;
    assign resp_acc         = I_LD_RESP_VALID & ~fifo_empty;

    wb_tag_fifo #(
        .LD_DEPTH (LD_DEPTH)
    ) u_tag_fifo (
        .clk      (I_CLK),
        .rst_n    (I_NRESET),
        .push     (issue_acc),
        .push_tag (I_LD_REG),
        .pop      (resp_acc),
        .pop_tag  (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) state <= WB_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hold_load = 1'b0;
        wb_en_d   = 1'b0;
        wb_load_d = 1'b0;
        wb_reg_d  = O_WB_REG;
        wb_data_d = O_WB_DATA;
        case (state)
            WB_IDLE: begin
                if (alu_acc) begin
                    wb_en_d   = 1'b1;
                    wb_reg_d  = I_ALU_REG;
                    wb_data_d = I_ALU_DATA;
                    if (resp_acc) begin
                        hold_load = 1'b1;
                        state_nxt = WB_HELD;
                    end
                end else if (resp_acc) begin
                    wb_en_d   = 1'b1;
                    wb_load_d = 1'b1;
                    wb_reg_d  = head_tag;
                    wb_data_d = I_LD_RESP_DATA;
                end
            end
            WB_HELD: begin
                wb_en_d   = 1'b1;
                wb_load_d = 1'b1;
                wb_reg_d  = hold_reg;
                wb_data_d = hold_data;
                // A response arriving while draining refills the buffer.
                if (resp_acc) hold_load = 1'b1;
                else          state_nxt = WB_IDLE;
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    // Clear is applied before set so a same-cycle re-issue keeps the bit.
    always_comb begin
        busy_nxt = O_BUSY;
        if (wb_load_d) busy_nxt = busy_nxt & ~reg_mask(wb_reg_d);
        if (issue_acc) busy_nxt = busy_nxt | reg_mask(I_LD_REG);
        err_d = (I_LD_RESP_VALID & fifo_empty)
              | (I_LD_ISSUE & fifo_full)
              | (alu_acc & O_BUSY[I_ALU_REG]);
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            hold_reg    <= '0;
            hold_data   <= '0;
            O_WB_ENABLE <= 1'b0;
            O_WB_REG    <= '0;
            O_WB_DATA   <= '0;
            O_BUSY      <= '0;
            O_ERROR     <= 1'b0;
        end else begin
            if (hold_load) begin
                hold_reg  <= head_tag;
                hold_data <= I_LD_RESP_DATA;
            end
            O_WB_ENABLE <= wb_en_d;
            O_WB_REG    <= wb_reg_d;
            O_WB_DATA   <= wb_data_d;
            O_BUSY      <= busy_nxt;
            O_ERROR     <= O_ERROR | err_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the write-back rules.
module tb_wb_arbiter;

    localparam int LD_DEPTH = 4;
    localparam int DW       = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [3:0]    alu_reg = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          ld_issue = 1'b0;
    logic [3:0]    ld_reg = '0;
    logic          ld_issue_ready;
    logic          ld_resp_valid = 1'b0;
    logic [DW-1:0] ld_resp_data = '0;
    logic          wb_enable;
    logic [3:0]    wb_reg;
    logic [DW-1:0] wb_data;
    logic [15:0]   busy;
    logic          error;

    always #5 clk = ~clk;

    wb_arbiter #(
        .LD_DEPTH   (LD_DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .I_CLK            (clk),
        .I_NRESET         (rst_n),
        .I_ALU_VALID      (alu_valid),
        .I_ALU_REG        (alu_reg),
        .I_ALU_DATA       (alu_data),
        .O_ALU_READY      (alu_ready),
        .I_LD_ISSUE       (ld_issue),
        .I_LD_REG         (ld_reg),
        .O_LD_ISSUE_READY (ld_issue_ready),
        .I_LD_RESP_VALID  (ld_resp_valid),
        .I_LD_RESP_DATA   (ld_resp_data),
        .O_WB_ENABLE      (wb_enable),
        .O_WB_REG         (wb_reg),
        .O_WB_DATA        (wb_data),
        .O_BUSY           (busy),
        .O_ERROR          (error)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: tags in flight, returned loads awaiting the write port.
    logic [3:0]  tag_q[$];
    logic [19:0] ret_q[$];
    logic [15:0] m_busy  = '0;
    logic        m_err   = 1'b0;
    logic        m_wb_en = 1'b0;
    logic [3:0]  m_wb_reg = '0;
    logic [15:0] m_wb_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        tag_q.delete();
        ret_q.delete();
        m_busy  = '0;
        m_err   = 1'b0;
        m_wb_en = 1'b0;
    endtask

    // Called just after a falling edge; applies one cycle and checks the result.
    task automatic step(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                        input logic li, input logic [3:0] lr,
                        input logic rv, input logic [15:0] rd);
        logic        alu_ok;
        logic        ld_ok;
        logic [19:0] ent;
        logic [15:0] nb;
        alu_ok = (ret_q.size() == 0);
        ld_ok  = (tag_q.size() < LD_DEPTH);
        check_eq("alu_ready", 32'(alu_ready), 32'(alu_ok));
        check_eq("ld_issue_ready", 32'(ld_issue_ready), 32'(ld_ok));
        alu_valid = av; alu_reg = ar; alu_data = ad;
        ld_issue = li; ld_reg = lr;
        ld_resp_valid = rv; ld_resp_data = rd;

        nb = m_busy;
        if (av && alu_ok && m_busy[ar]) m_err = 1'b1;
        if (li && !ld_ok) m_err = 1'b1;
        if (rv) begin
            if (tag_q.size() == 0) m_err = 1'b1;
            else ret_q.push_back({tag_q.pop_front(), rd});
        end
        if (li && ld_ok) tag_q.push_back(lr);
        m_wb_en = 1'b0;
        if (av && alu_ok) begin
            m_wb_en = 1'b1; m_wb_reg = ar; m_wb_data = ad;
        end else if (ret_q.size() > 0) begin
            ent = ret_q.pop_front();
            m_wb_en = 1'b1; m_wb_reg = ent[19:16]; m_wb_data = ent[15:0];
            nb[ent[19:16]] = 1'b0;
        end
        if (li && ld_ok) nb[lr] = 1'b1;
        m_busy = nb;

        @(posedge clk);
        @(negedge clk);
        check_eq("wb_enable", 32'(wb_enable), 32'(m_wb_en));
        if (m_wb_en) begin
            check_eq("wb_reg", 32'(wb_reg), 32'(m_wb_reg));
            check_eq("wb_data", 32'(wb_data), 32'(m_wb_data));
        end
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("error", 32'(error), 32'(m_err));
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0);
    endtask

    task automatic async_reset();
        alu_valid = 1'b0; ld_issue = 1'b0; ld_resp_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_wb_enable", 32'(wb_enable), 32'd0);
        check_eq("rst_wb_reg", 32'(wb_reg), 32'd0);
        check_eq("rst_wb_data", 32'(wb_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        logic       av;
        logic       li;
        logic       rv;

        repeat (2) @(negedge clk);
        check_eq("init_wb_enable", 32'(wb_enable), 32'd0);
        check_eq("init_busy", 32'(busy), 32'd0);
        check_eq("init_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        idle();

        // ALU only
        step(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 1'b0, 16'h0);
        check_eq("tp_alu_reg", 32'(wb_reg), 32'd3);
        check_eq("tp_alu_data", 32'(wb_data), 32'hBEEF);

        // Load round trip
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 1'b0, 16'h0);
        check_eq("tp_busy7", 32'(busy), 32'h0080);
        idle(); idle(); idle();
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 16'h1234);
        check_eq("tp_ld_data", 32'(wb_data), 32'h1234);
        idle();
        check_eq("tp_busy_clear", 32'(busy), 32'd0);

        // ALU and load response collide
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 1'b0, 16'h0);
        idle();
        step(1'b1, 4'd5, 16'h0011, 1'b0, 4'd0, 1'b1, 16'h2222);
        check_eq("tp_col_alu_reg", 32'(wb_reg), 32'd5);
        check_eq("tp_col_ready_low", 32'(alu_ready), 32'd0);
        idle();
        check_eq("tp_col_ld_reg", 32'(wb_reg), 32'd2);
        check_eq("tp_col_ld_data", 32'(wb_data), 32'h2222);
        check_eq("tp_col_ready_high", 32'(alu_ready), 32'd1);

        // Same-cycle clear and re-issue of R6
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd6, 1'b0, 16'h0);
        idle();
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd6, 1'b1, 16'h6666);
        check_eq("tp_r6_still_busy", 32'(busy[6]), 32'd1);
        idle();
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 16'h7777);
        check_eq("tp_r6_second_data", 32'(wb_data), 32'h7777);
        check_eq("tp_r6_cleared", 32'(busy[6]), 32'd0);

        // FIFO full, rejected issue, pointer wrap
        for (int i = 1; i <= 4; i++) step(1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 1'b0, 16'h0);
        check_eq("tp_full_ready", 32'(ld_issue_ready), 32'd0);
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 1'b0, 16'h0);
        check_eq("tp_full_error", 32'(error), 32'd1);
        check_eq("tp_r9_not_busy", 32'(busy[9]), 32'd0);
        for (int i = 1; i <= 4; i++) step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 16'(16'hA000 + i));
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 1'b0, 16'h0);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 16'h9999);
        check_eq("tp_wrap_reg", 32'(wb_reg), 32'd9);

        // Reset with loads in flight, then a stray response
        async_reset();
        idle();
        for (int i = 10; i <= 12; i++) step(1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 1'b0, 16'h0);
        async_reset();
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 16'h5555);
        check_eq("tp_stray_error", 32'(error), 32'd1);
        check_eq("tp_stray_no_write", 32'(wb_enable), 32'd0);

        // Random traffic obeying the protocol
        async_reset();
        for (int i = 0; i < 300; i++) begin
            av = ($urandom_range(0, 9) < 4);
            do r = 4'($urandom_range(0, 15)); while (m_busy[r]);
            li = ($urandom_range(0, 9) < 4) && (tag_q.size() < LD_DEPTH);
            rv = ($urandom_range(0, 9) < 5) && (tag_q.size() > 0);
            step(av, r, 16'($urandom), li, 4'($urandom_range(0, 15)), rv, 16'($urandom));
        end

        // Random traffic including protocol violations
        async_reset();
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom), 4'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom), 4'($urandom_range(0, 15)),
                 1'($urandom), 16'($urandom));
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
